// File: rtl/spi_pwm_multi.sv
// spi_pwm_multi
//   Multi-channel PWM generator configured over an SPI mode-0 slave port.
//   A 16-bit frame {rw, addr[6:0], data[7:0]} is shifted in MSB first.
//   Accepted writes update the register map:
//     0x00/0x01 out_en, 0x02/0x03 pwm_en, 0x04+k duty[k].
//   Duties are double-buffered and become active when the PWM counter wraps.
//
// Parameters
//   NUM_CH  : channel count (1..16)
//   CLK_DIV : clk cycles per PWM counter tick (>= 1)
//
// Ports
//   clk        : system clock, all state on its rising edge
//   rst_n      : synchronous active-low reset
//   sclk       : SPI clock (asynchronous)
//   copi       : SPI data in (asynchronous)
//   ncs        : SPI chip select, active low (asynchronous)
//   cipo       : SPI readback data, 0 unless readback is built in
//   out        : registered PWM outputs
//   frame_done : one-cycle pulse per accepted frame
//
// Optional feature
//   Define SPI_READBACK_EN to make frames with rw = 0 register reads.
module spi_pwm_multi #(
   parameter int NUM_CH  = 16,
   parameter int CLK_DIV = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              copi,
   input  logic              ncs,
   output logic              cipo,
   output logic [NUM_CH-1:0] out,
   output logic              frame_done
);

   localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
`ifdef SPI_READBACK_EN
   localparam logic          READ_OK   = 1'b1;
`else
   localparam logic          READ_OK   = 1'b0;
`endif

   typedef enum logic {S_IDLE, S_RECV} spi_state_t;
   spi_state_t state, state_nx;

   // [1] is the synchronized value, [2] its previous value for edge detection
   logic [2:0]        sclk_q, ncs_q;
   logic [1:0]        copi_q;
   logic              sclk_rise, ncs_rise, ncs_fall;
   logic [4:0]        bit_cnt;
   logic [15:0]       rx;
   logic              frame_ok;
   logic [6:0]        addr;
   logic [7:0]        data;

   logic [NUM_CH-1:0] out_en, pwm_en;
   logic [7:0]        duty     [NUM_CH];
   logic [7:0]        duty_act [NUM_CH];
   logic [PW-1:0]     presc;
   logic [7:0]        pwm_cnt;
   logic              tick, wrap;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign ncs_rise  = ncs_q[1]  & ~ncs_q[2];
   assign ncs_fall  = ~ncs_q[1] &  ncs_q[2];
   assign addr      = rx[14:8];
   assign data      = rx[7:0];
   assign tick      = (presc == PRESC_MAX);
   assign wrap      = tick && (pwm_cnt == 8'hFF);

   always_comb begin
      state_nx = state;
      frame_ok = 1'b0;
      case (state)
         S_IDLE: if (ncs_fall) state_nx = S_RECV;
         S_RECV: begin
            if (ncs_rise) begin
               state_nx = S_IDLE;
               frame_ok = (bit_cnt == 5'd16) && (rx[15] || READ_OK);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q  <= '0;
         copi_q  <= '0;
         ncs_q   <= '0;
         state   <= S_IDLE;
         bit_cnt <= '0;
         rx      <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         copi_q <= {copi_q[0], copi};
         ncs_q  <= {ncs_q[1:0], ncs};
         state  <= state_nx;
         if (ncs_fall) begin
            bit_cnt <= '0;
         end else if (state == S_RECV && !ncs_q[1] && sclk_rise && bit_cnt != 5'd16) begin
            rx      <= {rx[14:0], copi_q[1]};
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_en     <= '0;
         pwm_en     <= '0;
         presc      <= '0;
         pwm_cnt    <= '0;
         out        <= '0;
         frame_done <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            duty[k]     <= '0;
            duty_act[k] <= '0;
         end
      end else begin
         frame_done <= frame_ok;
         if (frame_ok && rx[15]) begin
            // enable bits at or above NUM_CH simply have no storage
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               if (addr == 7'(k / 8))     out_en[k] <= data[3'(k % 8)];
               if (addr == 7'(2 + k / 8)) pwm_en[k] <= data[3'(k % 8)];
               if (addr == 7'(4 + k))     duty[k]   <= data;
            end
         end
         if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
         end else begin
            presc <= presc + PW'(1);
         end
         // duty written in the wrap cycle is not yet visible here, so it
         // waits for the following wrap
         if (wrap) begin
            for (int unsigned k = 0; k < NUM_CH; k++) duty_act[k] <= duty[k];
         end
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            out[k] <= out_en[k] & (~pwm_en[k] | (duty_act[k] == 8'hFF) |
                                   (pwm_cnt < duty_act[k]));
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic       sclk_fall;
   logic [7:0] tx, rd_val;

   assign sclk_fall = ~sclk_q[1] & sclk_q[2];

   // after 8 bits, rx[6:0] holds the address just received
   always_comb begin
      rd_val = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (rx[6:0] == 7'(k / 8))     rd_val[3'(k % 8)] = out_en[k];
         if (rx[6:0] == 7'(2 + k / 8)) rd_val[3'(k % 8)] = pwm_en[k];
         if (rx[6:0] == 7'(4 + k))     rd_val            = duty[k];
      end
   end

   // load on the falling edge that follows bit 7, so the MSB is on cipo
   // before the master samples bit 8
   always_ff @(posedge clk) begin
      if (!rst_n || ncs_rise) begin
         tx <= '0;
      end else if (state == S_RECV && !ncs_q[1] && sclk_fall) begin
         if (bit_cnt == 5'd8 && !rx[7]) tx <= rd_val;
         else if (bit_cnt > 5'd8 && bit_cnt < 5'd16) tx <= {tx[6:0], 1'b0};
      end
   end

   assign cipo = tx[7];
`else
   assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_multi.sv
module tb_spi_pwm_multi;

   localparam int NCH = 12;
   localparam int DIV = 3;
   localparam int PER = 256 * DIV;
`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           sclk = 1'b0;
   logic           copi = 1'b0;
   logic           ncs = 1'b1;
   logic           cipo;
   logic [NCH-1:0] out;
   logic           frame_done;

   int errors = 0;
   int checks = 0;

   spi_pwm_multi #(.NUM_CH(NCH), .CLK_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(cipo), .out(out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [NCH-1:0] m_oen, m_pen;
   logic [7:0]     m_duty [NCH];
   logic [7:0]     m_act  [NCH];
   int             j;          // clk edges since reset released
   bit             frame_valid;
   int             pend_cnt;
   bit             pend_acc;
   logic [15:0]    pend_word;
   logic           ncs_prev = 1'b1;
   int             ncs_hi;
   logic [15:0]    frm_word;   // frame the driver sent, posted before ncs rises
   int             frm_bits;
   int             fd_seen = 0;
   logic [NCH-1:0] e_out;
   logic           fd_exp;
   int             cb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pwm_on(input logic [7:0] d, input int c);
      if (d == 8'h00) return 1'b0;
      if (d == 8'hFF) return 1'b1;
      return c < int'(d);
   endfunction

   function automatic logic [7:0] m_read(input logic [6:0] a);
      logic [7:0] v = '0;
      for (int k = 0; k < NCH; k++) begin
         if (a == 7'(k / 8))     v[k % 8] = m_oen[k];
         if (a == 7'(2 + k / 8)) v[k % 8] = m_pen[k];
         if (a == 7'(4 + k))     v = m_duty[k];
      end
      return v;
   endfunction

   task automatic m_write(input logic [6:0] a, input logic [7:0] d);
      for (int k = 0; k < NCH; k++) begin
         if (a == 7'(k / 8))     m_oen[k]  = d[k % 8];
         if (a == 7'(2 + k / 8)) m_pen[k]  = d[k % 8];
         if (a == 7'(4 + k))     m_duty[k] = d;
      end
   endtask

   // Cycle model: evaluated after every clk edge. Stimulus changes 2 ns after
   // a falling edge, so values seen here are those sampled at the last edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         j = 0; m_oen = '0; m_pen = '0; frame_valid = 0; pend_cnt = 0; pend_acc = 0;
         for (int k = 0; k < NCH; k++) begin m_duty[k] = '0; m_act[k] = '0; end
         chk("rst_out", 32'(out), 32'd0);
         chk("rst_frame_done", 32'(frame_done), 32'd0);
         chk("rst_cipo", 32'(cipo), 32'd0);
      end else begin
         j++;
         cb = ((j - 1) / DIV) % 256;
         for (int k = 0; k < NCH; k++) e_out[k] = m_oen[k] & (~m_pen[k] | pwm_on(m_act[k], cb));
         if (j % PER == 0) for (int k = 0; k < NCH; k++) m_act[k] = m_duty[k];
         fd_exp = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && pend_acc) begin
               fd_exp = 1'b1;
               if (pend_word[15]) m_write(pend_word[14:8], pend_word[7:0]);
            end
         end
         if (ncs && !ncs_prev) begin
            pend_acc  = frame_valid && frm_bits == 16 && (frm_word[15] || RB);
            pend_word = frm_word;
            pend_cnt  = 2;
            frame_valid = 0;
         end
         if (!ncs && ncs_prev) frame_valid = 1;
         chk("out", 32'(out), 32'(e_out));
         chk("frame_done", 32'(frame_done), 32'(fd_exp));
         if (frame_done) fd_seen++;
         if (ncs_hi >= 3 || !RB) chk("cipo_idle", 32'(cipo), 32'd0);
      end
      ncs_hi   = ncs ? ncs_hi + 1 : 0;
      ncs_prev = ncs;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   // nbits sclk pulses of w (MSB first); rst_at >= 0 pulses reset before that bit
   task automatic spi_xfer(input logic [15:0] w, input int nbits, input int rst_at);
      logic [7:0] rd_exp;
      step(1);
      ncs = 1'b0;
      step(5);
      rd_exp = m_read(w[14:8]);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            step(3);
            rst_n = 1'b1;
         end
         copi = w[15 - i];
         step(5);
         if (RB && !w[15] && nbits == 16 && i >= 8 && rst_at < 0)
            chk("cipo_read", 32'(cipo), 32'(rd_exp[15 - i]));
         sclk = 1'b1;
         step(5);
         sclk = 1'b0;
      end
      step(5);
      frm_word = w;
      frm_bits = nbits;
      ncs  = 1'b1;
      copi = 1'b0;
      step(8);
   endtask

   task automatic high_count(input int ch, input int exp, input string tag);
      int hi = 0;
      repeat (PER) begin
         @(negedge clk);
         hi += int'(out[ch]);
      end
      #2;
      chk(tag, 32'(hi), 32'(exp));
   endtask

   initial begin
      int fd0;
      step(5);
      rst_n = 1'b1;
      step(300);                              // idle after reset

      fd0 = fd_seen;
      spi_xfer(16'h80FF, 16, -1);             // out_en[7:0] = FF
      spi_xfer(16'h8200, 16, -1);             // pwm_en[7:0] = 00
      chk("fd_count_two_writes", 32'(fd_seen - fd0), 32'd2);
      step(PER);

      spi_xfer(16'h8201, 16, -1);             // pwm on ch0
      spi_xfer(16'h8440, 16, -1);             // duty0 = 0x40
      step(PER + 10);
      high_count(0, 64 * DIV, "duty40_high");

      spi_xfer(16'h84FF, 12, -1);             // short frame, discarded
      spi_xfer(16'h8480, 16, -1);
      step(PER + 10);
      high_count(0, 128 * DIV, "duty80_high");

      spi_xfer(16'h8400, 16, -1);
      step(PER + 10);
      high_count(0, 0, "duty00_high");
      spi_xfer(16'h84FF, 16, -1);
      step(PER + 10);
      high_count(0, PER, "dutyFF_high");
      spi_xfer(16'h8400, 16, -1);
      step(PER + 10);
      high_count(0, 0, "duty00_again_high");

      spi_xfer(16'h81FF, 16, -1);             // out_en[15:8], bits >= NCH ignored
      spi_xfer(16'h83FF, 16, -1);
      spi_xfer(16'h9077, 16, -1);             // unmapped, still frame_done
      spi_xfer(16'h82A5, 16, -1);
      fd0 = fd_seen;
      spi_xfer(16'h0200, 16, -1);             // read 0x02
      chk("fd_count_read", 32'(fd_seen - fd0), RB ? 32'd1 : 32'd0);
      spi_xfer(16'h0200, 16, -1);             // again: unchanged
      spi_xfer(16'h0144, 16, -1);             // read out_en[15:8]
      spi_xfer(16'h1300, 16, -1);             // read unmapped
      step(PER);

      spi_xfer(16'h80FF, 16, -1);
      spi_xfer(16'h82FF, 16, -1);
      for (int n = 0; n < 40; n++) begin
         logic [6:0] a;
         logic [7:0] d;
         logic       rw;
         int         nb;
         a  = 7'($urandom_range(0, 20));
         d  = 8'($urandom);
         rw = ($urandom_range(0, 3) != 0);
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
         spi_xfer({rw, a, d}, nb, -1);
         if ($urandom_range(0, 3) == 0) step(int'($urandom_range(50, PER)));
      end
      step(PER);

      spi_xfer(16'h80FF, 16, 6);              // reset mid-frame: discarded
      chk("after_mid_reset_out", 32'(out), 32'd0);
      spi_xfer(16'h8001, 16, -1);
      spi_xfer(16'h8201, 16, -1);
      spi_xfer(16'h8480, 16, -1);
      step(PER + 10);
      high_count(0, 128 * DIV, "post_reset_duty80_high");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
